// File: rtl/ddr4_reset_n_seq_pkg.sv
// ---------------------------------------------------------------------------
// ddr4_reset_n_seq_pkg
// Shared definitions for the DDR4 RESET_N power-up sequencer:
//   - seq_state_t      : sequencer FSM state encoding
//   - DEF_T_*          : default phase lengths in fabric clock cycles
//   - FAST_T_*         : shortened phase lengths used when the build defines
//                        DDR4_RST_SEQ_FAST_SIM_EN
//   - eff_cycles()     : maps a requested phase length of 0 onto 1 cycle
// ---------------------------------------------------------------------------
package ddr4_reset_n_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IOD_RST  = 3'd1,
        DL_LOAD  = 3'd2,
        RST_HOLD = 3'd3,
        CKE_WAIT = 3'd4,
        DONE     = 3'd5
    } seq_state_t;

    localparam int unsigned DEF_T_IOD_RST  = 8;
    localparam int unsigned DEF_T_RST_HOLD = 40000;   // 200 us at 200 MHz
    localparam int unsigned DEF_T_CKE_WAIT = 100000;  // 500 us at 200 MHz
    localparam int unsigned DEF_CNT_W      = 17;

    localparam int unsigned FAST_T_RST_HOLD = 64;
    localparam int unsigned FAST_T_CKE_WAIT = 128;

    // A phase cannot last zero cycles: the FSM always spends at least one
    // cycle in a state it enters.
    function automatic int unsigned eff_cycles(input int unsigned t);
        return (t == 0) ? 32'd1 : t;
    endfunction

endpackage

// File: rtl/ddr4_reset_n_seq_timer.sv
// ---------------------------------------------------------------------------
// ddr4_rst_seq_timer
// Loadable down-counter that times one sequencer phase.
// Loading N-1 on state entry makes done rise in the N-th cycle of the phase.
// The counter holds at zero instead of wrapping.
// Ports:
//   clk       in  fabric clock
//   rst       in  asynchronous active-high reset (counter -> 0)
//   load      in  load load_val on this edge (takes priority over counting)
//   load_val  in  CNT_W  value to load (phase length - 1)
//   done      out count has reached zero
// ---------------------------------------------------------------------------
module ddr4_rst_seq_timer #(
    parameter int unsigned CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/ddr4_reset_n_seq.sv
// ---------------------------------------------------------------------------
// ddr4_reset_n_seq
// DDR4 RESET_N / CKE power-up sequencer driving the RESET_N pad through an
// IOD serializer. Sequence: IDLE -> IOD_RST -> DL_LOAD -> RST_HOLD ->
// CKE_WAIT -> DONE. FORCE_RESET from DONE or CKE_WAIT re-enters RST_HOLD.
//
// Build option: defining DDR4_RST_SEQ_FAST_SIM_EN shortens RST_HOLD to 64
// cycles and CKE_WAIT to 128 cycles; IOD_RST keeps its parameter value.
//
// Ports:
//   FAB_CLK                    in   fabric clock
//   ARST                       in   asynchronous active-high reset
//   INIT_REQ                   in   start request (level accepted in IDLE)
//   FORCE_RESET                in   re-assert RESET_N from DONE / CKE_WAIT
//   DELAY_LINE_OUT_OF_RANGE_0  in   IOD delay-line status
//   TX_DATA_0                  out  4  RESET_N serializer lanes (bit 0 first)
//   OE_DATA_0                  out  4  pad output-enable lanes
//   TX_SYNC_RST / RX_SYNC_RST  out  IOD synchronous resets
//   DELAY_LINE_LOAD_0          out  one-cycle delay-line load pulse
//   DELAY_LINE_MOVE_0          out  tied 0
//   DELAY_LINE_DIRECTION_0     out  tied 0
//   ODT_EN_0                   out  tied 0
//   CKE_EN                     out  CKE may be driven high
//   INIT_DONE                  out  sequence complete
//   DL_ERR                     out  sticky delay-line out-of-range flag
// ---------------------------------------------------------------------------
module ddr4_reset_n_seq
    import ddr4_reset_n_seq_pkg::*;
#(
    parameter int unsigned T_IOD_RST  = DEF_T_IOD_RST,
    parameter int unsigned T_RST_HOLD = DEF_T_RST_HOLD,
    parameter int unsigned T_CKE_WAIT = DEF_T_CKE_WAIT,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic       FAB_CLK,
    input  logic       ARST,
    input  logic       INIT_REQ,
    input  logic       FORCE_RESET,
    input  logic       DELAY_LINE_OUT_OF_RANGE_0,
    output logic [3:0] TX_DATA_0,
    output logic [3:0] OE_DATA_0,
    output logic       TX_SYNC_RST,
    output logic       RX_SYNC_RST,
    output logic       DELAY_LINE_LOAD_0,
    output logic       DELAY_LINE_MOVE_0,
    output logic       DELAY_LINE_DIRECTION_0,
    output logic       ODT_EN_0,
    output logic       CKE_EN,
    output logic       INIT_DONE,
    output logic       DL_ERR
);

    localparam int unsigned IOD_RST_CYC = eff_cycles(T_IOD_RST);
`ifdef DDR4_RST_SEQ_FAST_SIM_EN
    localparam int unsigned RST_HOLD_CYC = FAST_T_RST_HOLD;
    localparam int unsigned CKE_WAIT_CYC = FAST_T_CKE_WAIT;
`else
    localparam int unsigned RST_HOLD_CYC = eff_cycles(T_RST_HOLD);
    localparam int unsigned CKE_WAIT_CYC = eff_cycles(T_CKE_WAIT);
`endif

    localparam logic [CNT_W-1:0] IOD_RST_LOAD  = CNT_W'(IOD_RST_CYC - 1);
    localparam logic [CNT_W-1:0] RST_HOLD_LOAD = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CKE_WAIT_LOAD = CNT_W'(CKE_WAIT_CYC - 1);

    seq_state_t       state_reg, state_next;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_done;

    // Output flops. Their next values are decoded from state_next so each
    // output changes on the same edge as the state it belongs to.
    logic reset_n_reg,   reset_n_next;
    logic oe_reg,        oe_next;
    logic sync_rst_reg,  sync_rst_next;
    logic dl_load_reg,   dl_load_next;
    logic cke_en_reg,    cke_en_next;
    logic init_done_reg, init_done_next;
    logic dl_err_reg;

    ddr4_rst_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (FAB_CLK),
        .rst      (ARST),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            state_reg     <= IDLE;
            reset_n_reg   <= 1'b0;
            oe_reg        <= 1'b0;
            sync_rst_reg  <= 1'b1;
            dl_load_reg   <= 1'b0;
            cke_en_reg    <= 1'b0;
            init_done_reg <= 1'b0;
            dl_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            reset_n_reg   <= reset_n_next;
            oe_reg        <= oe_next;
            sync_rst_reg  <= sync_rst_next;
            dl_load_reg   <= dl_load_next;
            cke_en_reg    <= cke_en_next;
            init_done_reg <= init_done_next;
            dl_err_reg    <= dl_err_reg | DELAY_LINE_OUT_OF_RANGE_0;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_load = 1'b0;
        timer_val  = '0;

        case (state_reg)
            IDLE:     if (INIT_REQ)   state_next = IOD_RST;
            IOD_RST:  if (timer_done) state_next = DL_LOAD;
            DL_LOAD:                  state_next = RST_HOLD;
            RST_HOLD: if (timer_done) state_next = CKE_WAIT;
            CKE_WAIT: begin
                if (FORCE_RESET)      state_next = RST_HOLD;
                else if (timer_done)  state_next = DONE;
            end
            DONE:     if (FORCE_RESET) state_next = RST_HOLD;
            default:                  state_next = IDLE;
        endcase

        // Every state entry restarts the phase timer; all re-entries of
        // RST_HOLD come from a different state, so a change test suffices.
        timer_load = (state_next != state_reg);
        case (state_next)
            IOD_RST:  timer_val = IOD_RST_LOAD;
            RST_HOLD: timer_val = RST_HOLD_LOAD;
            CKE_WAIT: timer_val = CKE_WAIT_LOAD;
            default:  timer_val = '0;
        endcase

        // RESET_N and CKE_EN are both decoded from the same next state, so
        // CKE_EN can only be high in a state where RESET_N is high.
        reset_n_next   = (state_next == CKE_WAIT) || (state_next == DONE);
        oe_next        = (state_next != IDLE);
        sync_rst_next  = (state_next == IDLE) || (state_next == IOD_RST);
        dl_load_next   = (state_next == DL_LOAD);
        cke_en_next    = (state_next == DONE);
        init_done_next = (state_next == DONE);
    end

    // All four serializer lanes come from one flop, so RESET_N can never
    // toggle within a fabric cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign TX_DATA_0[gi] = reset_n_reg;
            assign OE_DATA_0[gi] = oe_reg;
        end
    endgenerate

    assign TX_SYNC_RST            = sync_rst_reg;
    assign RX_SYNC_RST            = sync_rst_reg;
    assign DELAY_LINE_LOAD_0      = dl_load_reg;
    assign DELAY_LINE_MOVE_0      = 1'b0;
    assign DELAY_LINE_DIRECTION_0 = 1'b0;
    assign ODT_EN_0               = 1'b0;
    assign CKE_EN                 = cke_en_reg;
    assign INIT_DONE              = init_done_reg;
    assign DL_ERR                 = dl_err_reg;

endmodule

// File: tb/tb_ddr4_reset_n_seq.sv
// ---------------------------------------------------------------------------
// tb_ddr4_reset_n_seq
// Directed bench for the DDR4 RESET_N sequencer. The DUT is built with
// RST_HOLD=64 and CKE_WAIT=128 cycles so the timing matches the fast-sim
// lengths whether or not DDR4_RST_SEQ_FAST_SIM_EN is defined.
// Phase lengths from entry of IOD_RST: 8 IOD_RST + 1 DL_LOAD + 64 RST_HOLD
// + 128 CKE_WAIT = 201 cycles to DONE.
// ---------------------------------------------------------------------------
module tb_ddr4_reset_n_seq;

    logic       FAB_CLK = 1'b0;
    logic       ARST = 1'b0;
    logic       INIT_REQ = 1'b0;
    logic       FORCE_RESET = 1'b0;
    logic       DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
    logic [3:0] TX_DATA_0;
    logic [3:0] OE_DATA_0;
    logic       TX_SYNC_RST;
    logic       RX_SYNC_RST;
    logic       DELAY_LINE_LOAD_0;
    logic       DELAY_LINE_MOVE_0;
    logic       DELAY_LINE_DIRECTION_0;
    logic       ODT_EN_0;
    logic       CKE_EN;
    logic       INIT_DONE;
    logic       DL_ERR;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    always #5 FAB_CLK = ~FAB_CLK;

    ddr4_reset_n_seq #(
        .T_IOD_RST  (8),
        .T_RST_HOLD (64),
        .T_CKE_WAIT (128),
        .CNT_W      (17)
    ) dut (
        .FAB_CLK                   (FAB_CLK),
        .ARST                      (ARST),
        .INIT_REQ                  (INIT_REQ),
        .FORCE_RESET               (FORCE_RESET),
        .DELAY_LINE_OUT_OF_RANGE_0 (DELAY_LINE_OUT_OF_RANGE_0),
        .TX_DATA_0                 (TX_DATA_0),
        .OE_DATA_0                 (OE_DATA_0),
        .TX_SYNC_RST               (TX_SYNC_RST),
        .RX_SYNC_RST               (RX_SYNC_RST),
        .DELAY_LINE_LOAD_0         (DELAY_LINE_LOAD_0),
        .DELAY_LINE_MOVE_0         (DELAY_LINE_MOVE_0),
        .DELAY_LINE_DIRECTION_0    (DELAY_LINE_DIRECTION_0),
        .ODT_EN_0                  (ODT_EN_0),
        .CKE_EN                    (CKE_EN),
        .INIT_DONE                 (INIT_DONE),
        .DL_ERR                    (DL_ERR)
    );

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge FAB_CLK);
        #1;
    endtask

    // Lane-equality and CKE/RESET_N invariant, sampled on the falling edge.
    always @(negedge FAB_CLK) begin
        if (mon_en) begin
            checks++;
            if (!(TX_DATA_0 === 4'b0000 || TX_DATA_0 === 4'b1111) ||
                (CKE_EN === 1'b1 && TX_DATA_0 !== 4'b1111)) begin
                errors++;
                $display("FAIL invariant: tx=%b cke=%b, required tx in {0000,1111} and cke=1 only with tx=1111",
                         TX_DATA_0, CKE_EN);
            end
        end
    end

    task automatic test_reset();
        #3 ARST = 1'b1;
        #1;
        checks++; if (OE_DATA_0 !== 4'b0000) begin errors++; $display("FAIL reset_oe: got %b want 0000", OE_DATA_0); end
        checks++; if (TX_DATA_0 !== 4'b0000) begin errors++; $display("FAIL reset_tx: got %b want 0000", TX_DATA_0); end
        checks++; if (TX_SYNC_RST !== 1'b1 || RX_SYNC_RST !== 1'b1) begin errors++; $display("FAIL reset_sync: got tx=%b rx=%b want 1 1", TX_SYNC_RST, RX_SYNC_RST); end
        checks++; if (CKE_EN !== 1'b0 || INIT_DONE !== 1'b0) begin errors++; $display("FAIL reset_cke_done: got cke=%b done=%b want 0 0", CKE_EN, INIT_DONE); end
        checks++; if (DL_ERR !== 1'b0 || DELAY_LINE_LOAD_0 !== 1'b0) begin errors++; $display("FAIL reset_dl: got err=%b load=%b want 0 0", DL_ERR, DELAY_LINE_LOAD_0); end
        checks++; if ({DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, ODT_EN_0} !== 3'b000) begin errors++; $display("FAIL reset_const: got %b want 000", {DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, ODT_EN_0}); end
        repeat (3) tick();
        ARST = 1'b0;
        mon_en = 1'b1;
        tick();
        checks++; if (OE_DATA_0 !== 4'b0000 || TX_SYNC_RST !== 1'b1) begin errors++; $display("FAIL reset_release: got oe=%b sync=%b want 0000 1", OE_DATA_0, TX_SYNC_RST); end
        $display("test_reset: done, errors=%0d", errors);
    endtask

    task automatic test_idle_no_req();
        for (int i = 0; i < 1000; i++) begin
            tick();
            checks++;
            if (OE_DATA_0 !== 4'b0000 || INIT_DONE !== 1'b0) begin
                errors++;
                $display("FAIL idle_%0d: got oe=%b done=%b want 0000 0", i, OE_DATA_0, INIT_DONE);
            end
        end
        $display("test_idle_no_req: 1000 cycles, errors=%0d", errors);
    endtask

    task automatic test_full_sequence();
        INIT_REQ = 1'b1;
        tick();
        INIT_REQ = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (OE_DATA_0 !== 4'b1111 || TX_DATA_0 !== 4'b0000 || TX_SYNC_RST !== 1'b1 ||
                RX_SYNC_RST !== 1'b1 || DELAY_LINE_LOAD_0 !== 1'b0) begin
                errors++;
                $display("FAIL iod_rst_%0d: got oe=%b tx=%b sync=%b%b load=%b want 1111 0000 11 0",
                         i, OE_DATA_0, TX_DATA_0, TX_SYNC_RST, RX_SYNC_RST, DELAY_LINE_LOAD_0);
            end
            tick();
        end
        checks++;
        if (DELAY_LINE_LOAD_0 !== 1'b1 || TX_SYNC_RST !== 1'b0 || RX_SYNC_RST !== 1'b0 ||
            TX_DATA_0 !== 4'b0000 || OE_DATA_0 !== 4'b1111) begin
            errors++;
            $display("FAIL dl_load: got load=%b sync=%b%b tx=%b oe=%b want 1 00 0000 1111",
                     DELAY_LINE_LOAD_0, TX_SYNC_RST, RX_SYNC_RST, TX_DATA_0, OE_DATA_0);
        end
        tick();
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (TX_DATA_0 !== 4'b0000 || OE_DATA_0 !== 4'b1111 || CKE_EN !== 1'b0 ||
                DELAY_LINE_LOAD_0 !== 1'b0 || TX_SYNC_RST !== 1'b0) begin
                errors++;
                $display("FAIL rst_hold_%0d: got tx=%b oe=%b cke=%b load=%b sync=%b want 0000 1111 0 0 0",
                         i, TX_DATA_0, OE_DATA_0, CKE_EN, DELAY_LINE_LOAD_0, TX_SYNC_RST);
            end
            tick();
        end
        for (int i = 0; i < 128; i++) begin
            checks++;
            if (TX_DATA_0 !== 4'b1111 || CKE_EN !== 1'b0 || INIT_DONE !== 1'b0) begin
                errors++;
                $display("FAIL cke_wait_%0d: got tx=%b cke=%b done=%b want 1111 0 0",
                         i, TX_DATA_0, CKE_EN, INIT_DONE);
            end
            tick();
        end
        checks++;
        if (CKE_EN !== 1'b1 || INIT_DONE !== 1'b1 || TX_DATA_0 !== 4'b1111) begin
            errors++;
            $display("FAIL done_entry: got cke=%b done=%b tx=%b want 1 1 1111", CKE_EN, INIT_DONE, TX_DATA_0);
        end
        INIT_REQ = 1'b1;
        repeat (5) tick();
        INIT_REQ = 1'b0;
        checks++;
        if (INIT_DONE !== 1'b1 || CKE_EN !== 1'b1 || TX_SYNC_RST !== 1'b0 || OE_DATA_0 !== 4'b1111) begin
            errors++;
            $display("FAIL done_ignores_init: got done=%b cke=%b sync=%b oe=%b want 1 1 0 1111",
                     INIT_DONE, CKE_EN, TX_SYNC_RST, OE_DATA_0);
        end
        $display("test_full_sequence: done, errors=%0d", errors);
    endtask

    task automatic test_force_reset();
        int n;
        // From DONE
        FORCE_RESET = 1'b1;
        tick();
        FORCE_RESET = 1'b0;
        checks++;
        if (TX_DATA_0 !== 4'b0000 || CKE_EN !== 1'b0 || INIT_DONE !== 1'b0) begin
            errors++;
            $display("FAIL force_done: got tx=%b cke=%b done=%b want 0000 0 0", TX_DATA_0, CKE_EN, INIT_DONE);
        end
        n = 0;
        while (INIT_DONE !== 1'b1 && n < 400) begin tick(); n++; end
        checks++;
        if (n != 192) begin errors++; $display("FAIL force_done_len: got %0d cycles want 192", n); end

        // From CKE_WAIT: RST_HOLD restarts in full
        FORCE_RESET = 1'b1;
        tick();
        FORCE_RESET = 1'b0;
        repeat (64) tick();
        checks++;
        if (TX_DATA_0 !== 4'b1111) begin errors++; $display("FAIL force_cw_entry: got tx=%b want 1111", TX_DATA_0); end
        repeat (20) tick();
        FORCE_RESET = 1'b1;
        tick();
        FORCE_RESET = 1'b0;
        checks++;
        if (TX_DATA_0 !== 4'b0000 || CKE_EN !== 1'b0) begin
            errors++;
            $display("FAIL force_cke_wait: got tx=%b cke=%b want 0000 0", TX_DATA_0, CKE_EN);
        end
        n = 0;
        while (INIT_DONE !== 1'b1 && n < 400) begin tick(); n++; end
        checks++;
        if (n != 192) begin errors++; $display("FAIL force_cw_len: got %0d cycles want 192", n); end
        $display("test_force_reset: done, errors=%0d", errors);
    endtask

    task automatic test_force_ignored();
        int n;
        ARST = 1'b1;
        tick();
        ARST = 1'b0;
        tick();
        FORCE_RESET = 1'b1;
        repeat (3) tick();
        FORCE_RESET = 1'b0;
        checks++;
        if (OE_DATA_0 !== 4'b0000 || TX_SYNC_RST !== 1'b1) begin
            errors++;
            $display("FAIL force_idle: got oe=%b sync=%b want 0000 1", OE_DATA_0, TX_SYNC_RST);
        end
        INIT_REQ = 1'b1;
        tick();
        INIT_REQ = 1'b0;
        // n counts cycles from IOD_RST entry: 3 is IOD_RST, 8 DL_LOAD, 20 RST_HOLD
        n = 0;
        while (INIT_DONE !== 1'b1 && n < 400) begin
            FORCE_RESET = (n == 3 || n == 8 || n == 20);
            tick();
            n++;
        end
        FORCE_RESET = 1'b0;
        checks++;
        if (n != 201) begin errors++; $display("FAIL force_ignored_len: got %0d cycles want 201", n); end
        $display("test_force_ignored: done, errors=%0d", errors);
    endtask

    task automatic test_dl_err();
        int n;
        checks++;
        if (DL_ERR !== 1'b0) begin errors++; $display("FAIL dl_err_pre: got %b want 0", DL_ERR); end
        FORCE_RESET = 1'b1;
        tick();
        FORCE_RESET = 1'b0;
        repeat (64) tick();
        repeat (5) tick();
        DELAY_LINE_OUT_OF_RANGE_0 = 1'b1;
        tick();
        DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
        checks++;
        if (DL_ERR !== 1'b1) begin errors++; $display("FAIL dl_err_set: got %b want 1", DL_ERR); end
        n = 0;
        while (INIT_DONE !== 1'b1 && n < 400) begin tick(); n++; end
        checks++;
        if (n != 122) begin errors++; $display("FAIL dl_err_completes: got %0d cycles want 122", n); end
        repeat (10) tick();
        checks++;
        if (DL_ERR !== 1'b1) begin errors++; $display("FAIL dl_err_sticky: got %b want 1", DL_ERR); end
        ARST = 1'b1;
        #1;
        checks++;
        if (DL_ERR !== 1'b0) begin errors++; $display("FAIL dl_err_clear: got %b want 0", DL_ERR); end
        tick();
        ARST = 1'b0;
        tick();
        $display("test_dl_err: done, errors=%0d", errors);
    endtask

    task automatic test_async_reset_mid();
        INIT_REQ = 1'b1;
        tick();
        INIT_REQ = 1'b0;
        repeat (9) tick();
        repeat (30) tick();
        checks++;
        if (OE_DATA_0 !== 4'b1111 || TX_DATA_0 !== 4'b0000) begin
            errors++;
            $display("FAIL arst_pre: got oe=%b tx=%b want 1111 0000", OE_DATA_0, TX_DATA_0);
        end
        #2;
        ARST = 1'b1;
        INIT_REQ = 1'b1;
        #1;
        checks++;
        if (OE_DATA_0 !== 4'b0000 || TX_SYNC_RST !== 1'b1) begin
            errors++;
            $display("FAIL arst_async: got oe=%b sync=%b want 0000 1", OE_DATA_0, TX_SYNC_RST);
        end
        repeat (3) tick();
        checks++;
        if (OE_DATA_0 !== 4'b0000) begin errors++; $display("FAIL arst_held: got oe=%b want 0000", OE_DATA_0); end
        INIT_REQ = 1'b0;
        ARST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (OE_DATA_0 !== 4'b0000 || INIT_DONE !== 1'b0) begin
                errors++;
                $display("FAIL arst_stay_idle_%0d: got oe=%b done=%b want 0000 0", i, OE_DATA_0, INIT_DONE);
            end
        end
        INIT_REQ = 1'b1;
        tick();
        INIT_REQ = 1'b0;
        checks++;
        if (OE_DATA_0 !== 4'b1111 || TX_SYNC_RST !== 1'b1) begin
            errors++;
            $display("FAIL arst_restart: got oe=%b sync=%b want 1111 1", OE_DATA_0, TX_SYNC_RST);
        end
        $display("test_async_reset_mid: done, errors=%0d", errors);
    endtask

    initial begin
        test_reset();
        test_idle_no_req();
        test_full_sequence();
        test_force_reset();
        test_force_ignored();
        test_dl_err();
        test_async_reset_mid();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr4_reset_n_seq.md
DDR4_RESET_N_SEQ -- requirements
Module: ddr4_reset_n_seq

Interface
REQ-001 SHALL have parameter T_IOD_RST, default 8: cycles TX_SYNC_RST is held high.
REQ-002 SHALL have parameter T_RST_HOLD, default 40000: cycles RESET_N is held low (200 us at 200 MHz).
REQ-003 SHALL have parameter T_CKE_WAIT, default 100000: cycles from RESET_N high to CKE_EN (500 us).
REQ-004 SHALL have parameter CNT_W, default 17: width of the phase counter.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 SHALL have ports, with clock and reset first:
- FAB_CLK  in  1  fabric clock; the only clock.
- ARST  in  1  asynchronous, active-high reset.
- INIT_REQ  in  1  start pulse for the sequence; a level is accepted.
- FORCE_RESET  in  1  re-assert DDR4 RESET_N from DONE.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  status from the IOD.
- TX_DATA_0  out  4  RESET_N serializer lanes; bit 0 is sent first.
- OE_DATA_0  out  4  output-enable lanes.
- TX_SYNC_RST  out  1  IOD transmit synchronous reset.
- RX_SYNC_RST  out  1  IOD receive synchronous reset.
- DELAY_LINE_LOAD_0  out  1  delay-line load pulse.
- DELAY_LINE_MOVE_0  out  1  constant 0.
- DELAY_LINE_DIRECTION_0  out  1  constant 0.
- ODT_EN_0  out  1  constant 0.
- CKE_EN  out  1  permission for CKE to be driven high.
- INIT_DONE  out  1  sequence complete.
- DL_ERR  out  1  sticky delay-line out-of-range flag.

Function
REQ-007 SHALL implement the FSM states IDLE, IOD_RST, DL_LOAD, RST_HOLD, CKE_WAIT and DONE, with every output registered.
REQ-008 IDLE: OE_DATA_0=0000 (pad tri-stated), TX_DATA_0=0000, TX_SYNC_RST=RX_SYNC_RST=1; INIT_REQ=1 moves the FSM to IOD_RST on the next edge.
REQ-009 IOD_RST: sync resets stay 1, OE_DATA_0=1111, TX_DATA_0=0000; after T_IOD_RST cycles the FSM moves to DL_LOAD.
REQ-010 DL_LOAD: sync resets go 0 and DELAY_LINE_LOAD_0=1 for exactly one cycle, then the FSM moves to RST_HOLD.
REQ-011 RST_HOLD: TX_DATA_0=0000 and OE_DATA_0=1111 for T_RST_HOLD cycles, then the FSM moves to CKE_WAIT.
REQ-012 CKE_WAIT: TX_DATA_0=1111 for T_CKE_WAIT cycles, then the FSM moves to DONE.
REQ-013 DONE: TX_DATA_0=1111, CKE_EN=1, INIT_DONE=1; INIT_REQ is ignored.
REQ-014 FORCE_RESET=1 in DONE SHALL move the FSM to RST_HOLD, clearing CKE_EN and INIT_DONE in the same cycle TX_DATA_0 goes 0000.
REQ-015 FORCE_RESET in CKE_WAIT SHALL restart RST_HOLD; FORCE_RESET in any other state SHALL be ignored.
REQ-016 All four TX_DATA_0 bits SHALL always be equal, so there is no intra-cycle RESET_N edge.
REQ-017 CKE_EN SHALL never be 1 while TX_DATA_0 is 0000.
REQ-018 The counter SHALL clear on every state entry; the state exits when count == T-1; the counter SHALL never wrap.
REQ-019 DL_ERR SHALL set when DELAY_LINE_OUT_OF_RANGE_0=1 is sampled and SHALL clear only on ARST.

Reset
REQ-020 ARST SHALL force state IDLE, counter 0, DL_ERR=0 and all outputs to their IDLE values, asynchronously.
REQ-021 ARST asserted mid-sequence SHALL tri-state the pad immediately, and the sequence SHALL require a new INIT_REQ after release.

Configuration
REQ-022 Macro DDR4_RST_SEQ_FAST_SIM_EN defined: effective T_RST_HOLD=64 and T_CKE_WAIT=128, all other timings unchanged.
REQ-023 Macro DDR4_RST_SEQ_FAST_SIM_EN undefined: the parameter values apply.
REQ-024 A parameter T_* value of 0 SHALL be treated as 1.

Structure
REQ-025 The shared package SHALL hold the state enum, the default T_* constants and the fast-sim constants.
REQ-026 One sub-module, ddr4_rst_seq_timer (a loadable down-counter with a done flag), is natural; the FSM SHALL otherwise be flat.

Verification
REQ-027 With fast-sim on: ARST release, then INIT_REQ at cycle 10 -> TX_SYNC_RST=1 for 8 cycles, then one DELAY_LINE_LOAD_0 pulse, TX_DATA_0=0000 for 64 cycles, 1111, CKE_EN=1 exactly 128 cycles later.
REQ-028 No INIT_REQ for 1000 cycles -> OE_DATA_0=0000 throughout and INIT_DONE=0.
REQ-029 FORCE_RESET in DONE -> next cycle TX_DATA_0=0000 and CKE_EN=0; DONE is re-reached 64+128 cycles later.
REQ-030 ARST asserted at cycle 30 of RST_HOLD -> OE_DATA_0=0000 asynchronously; INIT_REQ held high during ARST has no effect.
REQ-031 DELAY_LINE_OUT_OF_RANGE_0 pulsed for 1 cycle in CKE_WAIT -> DL_ERR=1 until ARST, and the sequence still completes.
REQ-032 Every cycle -> TX_DATA_0 is in {0000, 1111}, and CKE_EN implies TX_DATA_0=1111.
